// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, LSB first.
// One bit is processed per clock. A start pulse loads the operands.
// A one-cycle done pulse marks completion, and R/COUT/OVF then hold
// until the next completion.
// Optional feature macro: SERIAL_ADDSUB_SAT_EN. When it is defined, R is
// saturated on signed overflow.
module serial_addsub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         S,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] R,
  output logic         COUT,
  output logic         OVF
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [N-1:0]   a_sh_r;
  logic [N-1:0]   b_sh_r;
  logic [N-1:0]   r_sh_r;
  logic [N-1:0]   r_out_r;
  logic [CW-1:0]  cnt_r;
  logic           sub_r;
  logic           carry_r;
  logic           busy_r;
  logic           done_r;
  logic           cout_r;
  logic           ovf_r;

  logic           accept_s;
  logic           last_s;
  logic           b_eff_s;
  logic           sum_s;
  logic           carry_s;
  logic [N-1:0]   r_next_s;
  logic [N-1:0]   r_final_s;

  // Carry out of a full adder: majority of its three inputs.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. A new operation is accepted in IDLE or DONE only.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // One full-adder slice, plus the completion value of R (saturated if enabled).
  always_comb begin
    last_s   = (state_r == RUN) && (cnt_r == CW'(N - 1));
    b_eff_s  = b_sh_r[0] ^ sub_r;
    sum_s    = a_sh_r[0] ^ b_eff_s ^ carry_r;
    carry_s  = maj3(a_sh_r[0], b_eff_s, carry_r);
    r_next_s = {sum_s, r_sh_r[N-1:1]};
`ifdef SERIAL_ADDSUB_SAT_EN
    // On the last bit, a_sh_r[0] is the sign of A, and carry_r is the carry into the MSB.
    if (carry_r ^ carry_s) begin
      if (a_sh_r[0]) begin
        r_final_s = {1'b1, {(N-1){1'b0}}};
      end else begin
        r_final_s = {1'b0, {(N-1){1'b1}}};
      end
    end else begin
      r_final_s = r_next_s;
    end
`else
    r_final_s = r_next_s;
`endif
  end

  // Datapath: load on accept, shift during RUN, publish results on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      r_sh_r  <= '0;
      r_out_r <= '0;
      cnt_r   <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_sh_r  <= A;
      b_sh_r  <= B;
      r_sh_r  <= '0;
      cnt_r   <= '0;
      sub_r   <= S;
      carry_r <= S;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else if (state_r == RUN) begin
      a_sh_r  <= {1'b0, a_sh_r[N-1:1]};
      b_sh_r  <= {1'b0, b_sh_r[N-1:1]};
      r_sh_r  <= r_next_s;
      carry_r <= carry_s;
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
        r_out_r <= r_final_s;
        cout_r  <= carry_s;
        ovf_r   <= carry_r ^ carry_s;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign R    = r_out_r;
  assign COUT = cout_r;
  assign OVF  = ovf_r;

endmodule
